// File: rtl/router_if.sv
// Port bundle for the 16-port serial router: per-port data, frame and valid
// lines in both directions, plus the per-input busy flags.
interface router_if;
  logic [15:0] din;
  logic [15:0] frame_n;
  logic [15:0] valid_n;
  logic [15:0] dout;
  logic [15:0] frameo_n;
  logic [15:0] valido_n;
  logic [15:0] busy_n;

  modport master (
    output din, frame_n, valid_n,
    input  dout, frameo_n, valido_n, busy_n
  );

  modport slave (
    input  din, frame_n, valid_n,
    output dout, frameo_n, valido_n, busy_n
  );
endinterface

// File: rtl/router.sv
// 16x16 serial packet router: 4-bit address, 5 pad cycles, then payload cut through with 1-cycle latency.
// Define ROUTER_RR_ARB_EN for per-output round-robin arbitration; the default is fixed priority (lowest input wins).
module router (
  input  logic      clock,
  input  logic      reset_n,
  router_if.slave   bus
);
  localparam int NP = 16;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PAD, S_DATA, S_DROP} state_t;

  state_t        state_q [NP];
  state_t        state_d [NP];
  logic [3:0]    cnt_q   [NP];
  logic [3:0]    cnt_d   [NP];
  logic [3:0]    addr_q  [NP];
  logic [3:0]    addr_d  [NP];
  logic [NP-1:0] won_q, won_d;
  logic [NP-1:0] armed_q;
  logic [NP-1:0] req, gnt;
  logic [NP-1:0] out_busy_q, out_busy_d, out_set, out_rel;
  logic [NP-1:0] dout_q, dout_d, frameo_q, frameo_d, valido_q, valido_d, busy;
`ifdef ROUTER_RR_ARB_EN
  logic [3:0]    ptr_q [NP];
  logic [3:0]    ptr_d [NP];
`endif

  // An input requests its output once, on the first padding cycle, if still framed.
  always_comb begin
    for (int i = 0; i < NP; i++)
      req[i] = (state_q[i] == S_PAD) && (cnt_q[i] == 4'd0) && !bus.frame_n[i];
  end

  always_comb begin : arb_p
    logic       found;
    logic [3:0] idx;
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
`ifdef ROUTER_RR_ARB_EN
    ptr_d = ptr_q;
`endif
    for (int d = 0; d < NP; d++) begin
      found = 1'b0;
      for (int k = 0; k < NP; k++) begin
`ifdef ROUTER_RR_ARB_EN
        idx = ptr_q[d] + 4'(k) + 4'd1;
`else
        idx = 4'(k);
`endif
        if (!found && !out_busy_q[d] && req[idx] && addr_q[idx] == 4'(d)) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
`ifdef ROUTER_RR_ARB_EN
          ptr_d[d] = idx;
`endif
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      addr_d[i]  = addr_q[i];
      won_d[i]   = won_q[i];
      case (state_q[i])
        S_IDLE:
          // Only a falling frame edge starts a packet; frame held low across reset is ignored.
          if (!bus.frame_n[i] && armed_q[i]) begin
            state_d[i] = S_ADDR;
            cnt_d[i]   = 4'd1;
            addr_d[i]  = {3'b000, bus.din[i]};
          end
        S_ADDR:
          if (bus.frame_n[i]) state_d[i] = S_IDLE;
          else begin
            addr_d[i][cnt_q[i][1:0]] = bus.din[i];
            if (cnt_q[i] == 4'd3) begin
              state_d[i] = S_PAD;
              cnt_d[i]   = 4'd0;
              won_d[i]   = 1'b0;
            end else cnt_d[i] = cnt_q[i] + 4'd1;
          end
        S_PAD:
          if (bus.frame_n[i]) begin
            state_d[i] = S_IDLE;
            won_d[i]   = 1'b0;
          end else begin
            if (cnt_q[i] == 4'd0) won_d[i] = gnt[i];
            if (cnt_q[i] == 4'd4) state_d[i] = won_q[i] ? S_DATA : S_DROP;
            else cnt_d[i] = cnt_q[i] + 4'd1;
          end
        S_DATA, S_DROP:
          if (bus.frame_n[i]) state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Crossbar: each granted DATA-phase input drives its output; unclaimed outputs idle.
  always_comb begin
    dout_d   = '0;
    frameo_d = '1;
    valido_d = '1;
    out_set  = '0;
    out_rel  = '0;
    for (int i = 0; i < NP; i++) begin
      if (gnt[i]) out_set[addr_q[i]] = 1'b1;
      if (state_q[i] == S_DATA) begin
        dout_d[addr_q[i]]   = bus.din[i];
        frameo_d[addr_q[i]] = bus.frame_n[i];
        valido_d[addr_q[i]] = bus.valid_n[i];
        if (bus.frame_n[i]) out_rel[addr_q[i]] = 1'b1;
      end else if (state_q[i] == S_PAD && won_q[i] && bus.frame_n[i]) begin
        out_rel[addr_q[i]] = 1'b1;
      end
      busy[i] = (state_q[i] == S_DROP) ||
                (state_q[i] == S_PAD && cnt_q[i] != 4'd0 && !won_q[i]);
    end
    out_busy_d = (out_busy_q & ~out_rel) | out_set;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NP; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        addr_q[i]  <= '0;
`ifdef ROUTER_RR_ARB_EN
        ptr_q[i]   <= 4'hF;
`endif
      end
      won_q      <= '0;
      armed_q    <= '0;
      out_busy_q <= '0;
      dout_q     <= '0;
      frameo_q   <= '1;
      valido_q   <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
`ifdef ROUTER_RR_ARB_EN
      ptr_q      <= ptr_d;
`endif
      won_q      <= won_d;
      armed_q    <= bus.frame_n;
      out_busy_q <= out_busy_d;
      dout_q     <= dout_d;
      frameo_q   <= frameo_d;
      valido_q   <= valido_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.frameo_n = frameo_q;
  assign bus.valido_n = valido_q;
  assign bus.busy_n   = ~busy;
endmodule

// File: tb/tb_router.sv
// Directed bench for router: per-cycle stimulus tables with hand-timed expected outputs.
module tb_router;
  localparam int MAXC = 48;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  router_if bus();
  router dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int scen     = 0;

  logic [15:0] s_din [MAXC], s_frame [MAXC], s_valid [MAXC];
  logic [15:0] e_dout[MAXC], e_frameo[MAXC], e_valido[MAXC], e_busy[MAXC];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear();
    for (int t = 0; t < MAXC; t++) begin
      s_din[t]  = '0; s_frame[t]  = '1; s_valid[t]  = '1;
      e_dout[t] = '0; e_frameo[t] = '1; e_valido[t] = '1; e_busy[t] = '1;
    end
  endtask

  // Packet starting at cycle 'start': 4 address bits, 5 garbage pad cycles, payload
  // (optional gap of gap_len cycles before bit gap_at). Expected output appears after the
  // edge that samples each data-phase cycle; a refused input is busy from start+4 until
  // the edge that samples its last bit.
  task automatic add_pkt(input int port, input int start, input logic [3:0] dst,
                         input logic [15:0] data, input int nbits,
                         input int gap_at, input int gap_len, input bit granted);
    int c;
    for (int k = 0; k < 9; k++) begin
      s_frame[start+k][port] = 1'b0;
      s_valid[start+k][port] = 1'b0;
      if (k < 4) s_din[start+k][port] = dst[k];
      else       s_din[start+k][port] = 1'b1;
    end
    c = start + 9;
    for (int b = 0; b < nbits; b++) begin
      if (b == gap_at)
        for (int g = 0; g < gap_len; g++) begin
          s_frame[c][port] = 1'b0; s_valid[c][port] = 1'b1; s_din[c][port] = 1'b0;
          c++;
        end
      s_frame[c][port] = (b == nbits - 1);
      s_valid[c][port] = 1'b0;
      s_din[c][port]   = data[b];
      c++;
    end
    if (granted)
      for (int t = start + 9; t < c; t++) begin
        e_dout[t][dst]   = s_din[t][port];
        e_frameo[t][dst] = s_frame[t][port];
        e_valido[t][dst] = s_valid[t][port];
      end
    else
      for (int t = start + 4; t <= c - 2; t++) e_busy[t][port] = 1'b0;
  endtask

  // Packet whose frame rises at cycle start+off (inside address or padding).
  task automatic add_abort(input int port, input int start, input logic [3:0] dst, input int off);
    for (int k = 0; k < off; k++) begin
      s_frame[start+k][port] = 1'b0;
      s_valid[start+k][port] = 1'b0;
      if (k < 4) s_din[start+k][port] = dst[k];
      else       s_din[start+k][port] = 1'b1;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dout"},     bus.dout,     16'h0000);
    check({tag, "_frameo_n"}, bus.frameo_n, 16'hFFFF);
    check({tag, "_valido_n"}, bus.valido_n, 16'hFFFF);
    check({tag, "_busy_n"},   bus.busy_n,   16'hFFFF);
  endtask

  task automatic run(input int n);
    for (int t = 0; t < n; t++) begin
      bus.din     = s_din[t];
      bus.frame_n = s_frame[t];
      bus.valid_n = s_valid[t];
      @(posedge clock);
      #1;
      check($sformatf("s%0d_t%0d_dout", scen, t),     bus.dout,     e_dout[t]);
      check($sformatf("s%0d_t%0d_frameo_n", scen, t), bus.frameo_n, e_frameo[t]);
      check($sformatf("s%0d_t%0d_valido_n", scen, t), bus.valido_n, e_valido[t]);
      check($sformatf("s%0d_t%0d_busy_n", scen, t),   bus.busy_n,   e_busy[t]);
    end
    scen++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit win9;
    reset_n     = 1'b0;
    bus.din     = '0;
    bus.frame_n = '1;
    bus.valid_n = '1;
    repeat (2) @(posedge clock);
    #1;
    check_idle("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Single packet: input 3 -> output 5, payload A5.
    clear(); add_pkt(3, 1, 4'd5, 16'h00A5, 8, -1, 0, 1'b1); run(24);

    // Two disjoint paths in the same cycle.
    clear();
    add_pkt(0, 1, 4'd2, 16'h003C, 8, -1, 0, 1'b1);
    add_pkt(1, 1, 4'd7, 16'h00C3, 8, -1, 0, 1'b1);
    run(24);

    // Contention on output 6, twice; loser is busy until its own frame ends.
    for (int r = 0; r < 2; r++) begin
`ifdef ROUTER_RR_ARB_EN
      win9 = (r == 1);
`else
      win9 = 1'b0;
`endif
      clear();
      add_pkt(4, 1, 4'd6, 16'h005A, 8, -1, 0, !win9);
      add_pkt(9, 1, 4'd6, 16'h0016, 5, -1, 0, win9);
      run(24);
    end

    // Two-cycle gap before payload bit 3.
    clear(); add_pkt(2, 1, 4'd11, 16'h00B7, 8, 3, 2, 1'b1); run(26);

    // Full permutation: input i -> output 15-i, 16-bit payloads.
    clear();
    for (int i = 0; i < 16; i++)
      add_pkt(i, 1, 4'(15 - i), 16'(16'h9E37 * (i + 1)), 16, -1, 0, 1'b1);
    run(30);

    // Output release boundary: last bit of input 5 sampled at 17; arbitration at 17 is
    // refused (input 7), arbitration at 18 is granted (input 6).
    clear();
    add_pkt(5, 1,  4'd1, 16'h00E1, 8, -1, 0, 1'b1);
    add_pkt(7, 13, 4'd1, 16'h000D, 4, -1, 0, 1'b0);
    add_pkt(6, 14, 4'd1, 16'h0072, 8, -1, 0, 1'b1);
    run(34);

    // Aborts in padding (after winning) and in address; output 3 must be free again.
    clear();
    add_abort(8, 1, 4'd3, 6);
    add_abort(11, 1, 4'd12, 2);
    add_pkt(10, 5, 4'd3, 16'h00C6, 8, -1, 0, 1'b1);
    run(26);

    // Reset during payload bit 3, frame held low through and after reset.
    clear(); add_pkt(3, 1, 4'd5, 16'h00A5, 8, -1, 0, 1'b1); run(13);
    bus.din     = s_din[13];
    bus.frame_n = s_frame[13];
    bus.valid_n = s_valid[13];
    #2 reset_n = 1'b0;
    #1 check_idle("rst_async");
    bus.frame_n = 16'hFFF7;
    bus.valid_n = '1;
    bus.din     = '0;
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(posedge clock);
      #1;
      check_idle($sformatf("rst_hold%0d", t));
    end
    clear(); add_pkt(3, 1, 4'd5, 16'h0096, 8, -1, 0, 1'b1); run(24);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
